// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, state and cause types for the pipeline controller
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
  localparam int          NUM_INT_DEF    = 6;

  // mem_excp bit positions, listed highest priority first
  localparam int EXC_INT   = 0;
  localparam int EXC_FADEL = 1;
  localparam int EXC_RI    = 2;
  localparam int EXC_OV    = 3;
  localparam int EXC_SYS   = 4;
  localparam int EXC_BP    = 5;
  localparam int EXC_DADEL = 6;
  localparam int EXC_ADES  = 7;
  localparam int EXC_ERET  = 8;

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0A;
  localparam logic [4:0] CODE_OV   = 5'h0C;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HOLD,
    ST_COMMIT,
    ST_FLUSH
  } state_e;

  typedef enum logic [3:0] {
    K_NONE,
    K_INT,
    K_FADEL,
    K_RI,
    K_OV,
    K_SYS,
    K_BP,
    K_DADEL,
    K_ADES,
    K_ERET
  } kind_e;

  function automatic logic [4:0] kind_code(kind_e k);
    logic [4:0] c;
    c = CODE_INT;
    case (k)
      K_FADEL, K_DADEL: c = CODE_ADEL;
      K_ADES:           c = CODE_ADES;
      K_RI:             c = CODE_RI;
      K_OV:             c = CODE_OV;
      K_SYS:            c = CODE_SYS;
      K_BP:             c = CODE_BP;
      default:          c = CODE_INT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stage requests, MEM exception inputs and CP0/stall outputs
interface pipe_ctrl_if #(
  parameter int NUM_INT = 6
) ();

  logic               if_stallreq;
  logic               id_stallreq;
  logic               ex_stallreq;
  logic               mem_stallreq;
  logic [31:0]        mem_excp;
  logic [31:0]        mem_pc;
  logic               mem_inslot;
  logic [31:0]        mem_badvaddr;
  logic [NUM_INT-1:0] ext_int;
  logic [31:0]        cp0_status;
  logic [31:0]        cp0_epc;

  logic               if_stall;
  logic               id_stall;
  logic               ex_stall;
  logic               mem_stall;
  logic               wb_stall;
  logic               flush;
  logic [31:0]        flush_pc;
  logic               cp0_excwe;
  logic [4:0]         cp0_exccode;
  logic [31:0]        cp0_epc_wd;
  logic [31:0]        cp0_badv_wd;
  logic               cp0_eret;
  logic [NUM_INT-1:0] int_pending;
  logic [31:0]        stall_cnt;

  modport master (
    output if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
    output mem_excp, mem_pc, mem_inslot, mem_badvaddr, ext_int, cp0_status, cp0_epc,
    input  if_stall, id_stall, ex_stall, mem_stall, wb_stall, flush, flush_pc,
    input  cp0_excwe, cp0_exccode, cp0_epc_wd, cp0_badv_wd, cp0_eret, int_pending, stall_cnt
  );

  modport slave (
    input  if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
    input  mem_excp, mem_pc, mem_inslot, mem_badvaddr, ext_int, cp0_status, cp0_epc,
    output if_stall, id_stall, ex_stall, mem_stall, wb_stall, flush, flush_pc,
    output cp0_excwe, cp0_exccode, cp0_epc_wd, cp0_badv_wd, cp0_eret, int_pending, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_int_sync.sv
// rtl/pipe_ctrl_int_sync.sv - two-flop synchroniser for the external interrupt lines
module int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall vector, exception/ERET resolution, redirect and CP0 write strobes
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          NUM_INT    = NUM_INT_DEF
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  state_e state_q, state_d;
  kind_e  kind_q, kind_d, kind_sel;

  logic [NUM_INT-1:0] int_pend;
  logic               int_take;
  logic               if_stall, id_stall, ex_stall, mem_stall, wb_stall;

  logic        flush_q, flush_d, excwe_q, excwe_d, eret_q, eret_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] flush_pc_q, flush_pc_d, epc_wd_q, epc_wd_d, badv_q, badv_d;
  logic [31:0] stall_cnt_q;
  logic        unused_bits;

  int_sync #(.WIDTH(NUM_INT)) u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.ext_int),
    .sync_o  (int_pend)
  );

  assign int_take = bus.cp0_status[0] & ~bus.cp0_status[1]
                  & (|(6'(int_pend) & bus.cp0_status[15:10]));
  assign unused_bits = ^{bus.mem_excp[31:9], bus.mem_excp[EXC_INT],
                         bus.cp0_status[31:16], bus.cp0_status[9:2]};

  // The controller injects the interrupt on the MEM instruction itself
  always_comb begin
    kind_sel = K_NONE;
    if (int_take)                     kind_sel = K_INT;
    else if (bus.mem_excp[EXC_FADEL]) kind_sel = K_FADEL;
    else if (bus.mem_excp[EXC_RI])    kind_sel = K_RI;
    else if (bus.mem_excp[EXC_OV])    kind_sel = K_OV;
    else if (bus.mem_excp[EXC_SYS])   kind_sel = K_SYS;
    else if (bus.mem_excp[EXC_BP])    kind_sel = K_BP;
    else if (bus.mem_excp[EXC_DADEL]) kind_sel = K_DADEL;
    else if (bus.mem_excp[EXC_ADES])  kind_sel = K_ADES;
    else if (bus.mem_excp[EXC_ERET])  kind_sel = K_ERET;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      kind_q  <= K_NONE;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    unique case (state_q)
      ST_RUN: begin
        if (kind_sel != K_NONE) begin
          kind_d  = kind_sel;
          state_d = bus.mem_stallreq ? ST_HOLD : ST_COMMIT;
        end
      end
      ST_HOLD:   if (!bus.mem_stallreq) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_FLUSH;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    ex_stall  = 1'b0;
    id_stall  = 1'b0;
    if_stall  = 1'b0;
    wb_stall  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        mem_stall = bus.mem_stallreq;
        ex_stall  = mem_stall | bus.ex_stallreq;
        id_stall  = ex_stall | bus.id_stallreq;
        if_stall  = id_stall | bus.if_stallreq;
      end
      ST_HOLD, ST_COMMIT: begin
        mem_stall = 1'b1;
        ex_stall  = 1'b1;
        id_stall  = 1'b1;
        if_stall  = 1'b1;
        wb_stall  = 1'b1;
      end
      default: ;
    endcase
  end

  // CP0 strobes and redirect are loaded during COMMIT so they are live only in FLUSH
  always_comb begin
    flush_d    = 1'b0;
    excwe_d    = 1'b0;
    eret_d     = 1'b0;
    code_d     = 5'd0;
    flush_pc_d = 32'd0;
    epc_wd_d   = 32'd0;
    badv_d     = 32'd0;
    if (state_q == ST_COMMIT) begin
      flush_d = 1'b1;
      if (kind_q == K_ERET) begin
        eret_d     = 1'b1;
        flush_pc_d = bus.cp0_epc;
      end else begin
        excwe_d    = 1'b1;
        flush_pc_d = EXC_VECTOR;
        code_d     = kind_code(kind_q);
        epc_wd_d   = bus.mem_inslot ? bus.mem_pc - 32'd4 : bus.mem_pc;
        if (kind_q == K_FADEL)                         badv_d = bus.mem_pc;
        else if (kind_q == K_DADEL || kind_q == K_ADES) badv_d = bus.mem_badvaddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q     <= 1'b0;
      excwe_q     <= 1'b0;
      eret_q      <= 1'b0;
      code_q      <= 5'd0;
      flush_pc_q  <= 32'd0;
      epc_wd_q    <= 32'd0;
      badv_q      <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      flush_q    <= flush_d;
      excwe_q    <= excwe_d;
      eret_q     <= eret_d;
      code_q     <= code_d;
      flush_pc_q <= flush_pc_d;
      epc_wd_q   <= epc_wd_d;
      badv_q     <= badv_d;
      if (!wb_stall && if_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.if_stall    = if_stall;
  assign bus.id_stall    = id_stall;
  assign bus.ex_stall    = ex_stall;
  assign bus.mem_stall   = mem_stall;
  assign bus.wb_stall    = wb_stall;
  assign bus.flush       = flush_q;
  assign bus.flush_pc    = flush_pc_q;
  assign bus.cp0_excwe   = excwe_q;
  assign bus.cp0_eret    = eret_q;
  assign bus.cp0_exccode = code_q;
  assign bus.cp0_epc_wd  = epc_wd_q;
  assign bus.cp0_badv_wd = badv_q;
  assign bus.int_pending = int_pend;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with a cause-table reference model
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.NUM_INT(6)) bus ();

  pipe_ctrl #(.EXC_VECTOR(32'hBFC00380), .NUM_INT(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        eret;
    logic [31:0] pc;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        chk_badv;
    logic [31:0] badv;
  } txn_t;

  txn_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = 0;
  logic [5:0]  exp_pend = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // a stage stalls when it or any later stage requests; req[0]=IF .. req[3]=MEM
  function automatic logic [4:0] cascade(input logic [3:0] req);
    logic [4:0] v;
    v = 5'd0;
    for (int j = 0; j < 4; j++) v[4-j] = ((req >> j) != 4'd0);
    return v;
  endfunction

  function automatic txn_t model(input logic [31:0] excp, input logic [31:0] status,
                                 input logic [31:0] epc_in, input logic [31:0] pc,
                                 input logic inslot, input logic [31:0] badv,
                                 output bit take);
    logic [4:0] codes [9];
    logic       active;
    txn_t       t;
    codes = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05, 5'h00};
    t = '{eret: 1'b0, pc: 32'hBFC00380, code: 5'd0, epc: 32'd0, chk_badv: 1'b0, badv: 32'd0};
    take = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) active = status[0] && !status[1] && ((exp_pend & status[15:10]) != 6'd0);
      else        active = excp[i];
      if (active && !take) begin
        take = 1;
        if (i == 8) begin
          t.eret = 1'b1;
          t.pc   = epc_in;
        end else begin
          t.code = codes[i];
          t.epc  = inslot ? pc - 32'd4 : pc;
          if (i == 1)           begin t.chk_badv = 1'b1; t.badv = pc;   end
          if (i == 6 || i == 7) begin t.chk_badv = 1'b1; t.badv = badv; end
        end
      end
    end
    return t;
  endfunction

  // exp_st packs {if,id,ex,mem,wb}
  task automatic step(input logic [4:0] exp_st, input logic exp_flush, input bit count);
    @(negedge clk);
    chk("stalls", {27'd0, bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall, bus.wb_stall},
        {27'd0, exp_st});
    chk("flush_level", {31'd0, bus.flush}, {31'd0, exp_flush});
    chk("stall_cnt", bus.stall_cnt, exp_cnt);
    if (count) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic exc_seq(input logic [31:0] excp, input logic [31:0] pc, input logic inslot,
                         input logic [31:0] badv, input logic [31:0] epc_in,
                         input logic [31:0] status, input int k);
    txn_t t;
    bit   take;
    t = model(excp, status, epc_in, pc, inslot, badv, take);
    bus.if_stallreq  = 1'b0;
    bus.id_stallreq  = 1'b0;
    bus.ex_stallreq  = 1'b0;
    bus.mem_stallreq = (k > 0);
    bus.mem_excp     = excp;
    bus.mem_pc       = pc;
    bus.mem_inslot   = inslot;
    bus.mem_badvaddr = badv;
    bus.cp0_epc      = epc_in;
    bus.cp0_status   = status;
    if (!take) begin
      repeat (3) step(5'b00000, 1'b0, 1'b0);
    end else begin
      exp_q.push_back(t);
      step((k > 0) ? 5'b11110 : 5'b00000, 1'b0, k > 0);
      for (int i = 0; i < k; i++) begin
        bus.mem_stallreq = (i < k - 1);
        step(5'b11111, 1'b0, 1'b0);
      end
      step(5'b11111, 1'b0, 1'b0);
      bus.mem_excp   = 32'd0;
      bus.cp0_status = 32'd0;
      step(5'b00000, 1'b1, 1'b0);
      step(5'b00000, 1'b0, 1'b0);
    end
    bus.mem_excp     = 32'd0;
    bus.mem_stallreq = 1'b0;
    bus.cp0_status   = 32'd0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.flush) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_flush: got flush_pc %h expected no flush", bus.flush_pc);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        chk("flush_pc", bus.flush_pc, t.pc);
        chk("cp0_eret", {31'd0, bus.cp0_eret}, {31'd0, t.eret});
        chk("cp0_excwe", {31'd0, bus.cp0_excwe}, {31'd0, ~t.eret});
        if (!t.eret) begin
          chk("exccode", {27'd0, bus.cp0_exccode}, {27'd0, t.code});
          chk("epc_wd", bus.cp0_epc_wd, t.epc);
          if (t.chk_badv) chk("badv_wd", bus.cp0_badv_wd, t.badv);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0]  req;
    logic [4:0]  cv;
    logic [31:0] ex;
    bus.if_stallreq  = 1'b0;
    bus.id_stallreq  = 1'b0;
    bus.ex_stallreq  = 1'b0;
    bus.mem_stallreq = 1'b0;
    bus.mem_excp     = 32'd0;
    bus.mem_pc       = 32'd0;
    bus.mem_inslot   = 1'b0;
    bus.mem_badvaddr = 32'd0;
    bus.ext_int      = 6'd0;
    bus.cp0_status   = 32'd0;
    bus.cp0_epc      = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_strobes", {29'd0, bus.flush, bus.cp0_excwe, bus.cp0_eret}, 32'd0);
    chk("rst_flush_pc", bus.flush_pc, 32'd0);
    chk("rst_cp0_data", bus.cp0_epc_wd | bus.cp0_badv_wd | {27'd0, bus.cp0_exccode}, 32'd0);
    chk("rst_pending", {26'd0, bus.int_pending}, 32'd0);
    step(5'b00000, 1'b0, 1'b0);

    bus.ex_stallreq = 1'b1;
    repeat (4) step(5'b11100, 1'b0, 1'b1);
    bus.ex_stallreq = 1'b0;

    for (int n = 0; n < 40; n++) begin
      req = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.if_stallreq  = req[0];
      bus.id_stallreq  = req[1];
      bus.ex_stallreq  = req[2];
      bus.mem_stallreq = req[3];
      cv = cascade(req);
      step(cv, 1'b0, cv[4]);
    end
    bus.if_stallreq  = 1'b0;
    bus.id_stallreq  = 1'b0;
    bus.ex_stallreq  = 1'b0;
    bus.mem_stallreq = 1'b0;

    exc_seq(32'h0000_0008, 32'h8000_0010, 1'b0, 32'd0, 32'd0, 32'd0, 0);
    exc_seq(32'h0000_0010, 32'h8000_0024, 1'b1, 32'd0, 32'd0, 32'd0, 0);
    exc_seq(32'h0000_0080, 32'h8000_0100, 1'b0, 32'h1234_5679, 32'd0, 32'd0, 3);
    exc_seq(32'h0000_0100, 32'h8000_0200, 1'b0, 32'd0, 32'h8000_1000, 32'd0, 0);
    exc_seq(32'h0000_0042, 32'h8000_0302, 1'b0, 32'hDEAD_BEE0, 32'd0, 32'd0, 1);
    exc_seq(32'h0000_0040, 32'h0000_0000, 1'b1, 32'h0000_0003, 32'd0, 32'd0, 0);

    for (int n = 0; n < 30; n++) begin
      ex = $urandom & 32'h0000_01FE;
      if (ex == 32'd0) ex = 32'h0000_0100;
      ex = ex | ($urandom & 32'hFFFF_FE00);
      exc_seq(ex, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom, $urandom_range(0, 3));
    end

    bus.ext_int = 6'b000100;
    @(negedge clk);
    chk("pending_0edge", {26'd0, bus.int_pending}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pending_1edge", {26'd0, bus.int_pending}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pending_2edge", {26'd0, bus.int_pending}, 32'h0000_0004);
    @(posedge clk);
    #1;
    exp_pend = 6'b000100;
    exc_seq(32'h0000_0005, 32'h8000_0400, 1'b0, 32'd0, 32'd0, 32'h0000_1001, 0);
    exc_seq(32'h0000_0001, 32'h8000_0400, 1'b0, 32'd0, 32'd0, 32'h0000_1003, 0);
    bus.ext_int = 6'd0;
    repeat (3) step(5'b00000, 1'b0, 1'b0);
    exp_pend = 6'd0;

    bus.mem_excp     = 32'h0000_0008;
    bus.mem_stallreq = 1'b1;
    step(5'b11110, 1'b0, 1'b1);
    step(5'b11111, 1'b0, 1'b0);
    rst              = 1'b1;
    bus.mem_excp     = 32'd0;
    bus.mem_stallreq = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_cnt = 32'd0;
    repeat (3) step(5'b00000, 1'b0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller. Produces the per-stage stall vector and the flush pulse consumed by every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Resolves exceptions and ERET presented by the MEM stage and generates the redirect PC.
- Writes EPC, ExcCode and EXL to CP0.
- Synchronises external interrupt lines and keeps a stall-cycle performance counter.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry address.
- NUM_INT, 6, number of external hardware interrupt lines.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_stallreq  in  1  IF requests stall (fetch not ready)
- id_stallreq  in  1  ID requests stall (load-use hazard)
- ex_stallreq  in  1  EX requests stall (multicycle mul/div)
- mem_stallreq  in  1  MEM requests stall (data bus not ready)
- mem_excp  in  32  MEM-stage exception flags; bit layout is in the Behaviour section
- mem_pc  in  32  PC of the MEM-stage instruction
- mem_inslot  in  1  MEM instruction is in a delay slot
- mem_badvaddr  in  32  faulting address for AdEL/AdES
- ext_int  in  NUM_INT  asynchronous external interrupt lines
- cp0_status  in  32  CP0 Status: IE=bit0, EXL=bit1, IM=bits[15:10]
- cp0_epc  in  32  CP0 EPC, used as the ERET target
- if_stall, id_stall, ex_stall, mem_stall, wb_stall  out  1 each  stage freeze
- flush  out  1  clear all pipeline registers
- flush_pc  out  32  redirect target, valid while flush=1
- cp0_excwe  out  1  one-cycle CP0 exception write strobe
- cp0_exccode  out  5  ExcCode to write
- cp0_epc_wd  out  32  EPC value to write
- cp0_badv_wd  out  32  BadVAddr value to write
- cp0_eret  out  1  clear-EXL strobe
- int_pending  out  NUM_INT  synchronised interrupt lines, for Cause.IP
- stall_cnt  out  32  count of cycles with wb_stall=0 and if_stall=1

Behaviour:
- Reset: every output is 0, FSM goes to RUN, both synchroniser stages are 0, stall_cnt=0.
- mem_excp bit layout: bit0 Int, bit1 fetch AdEL, bit2 RI, bit3 Ov, bit4 Sys, bit5 Bp, bit6 data AdEL, bit7 AdES, bit8 ERET. All other bits are ignored.
- Priority (highest first): Int, fetch AdEL, RI, Ov, Sys, Bp, data AdEL, AdES, ERET.
- ExcCode values: Int 0x00, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0A, Ov 0x0C.
- Int is taken only when IE=1, EXL=0, and (int_pending & IM) != 0. The interrupt is injected through the bit0 path of the MEM instruction.
- Interrupt sync: two flops per line; int_pending equals the second stage.
- Stall vector in RUN (combinational):
  - wb_stall=0
  - mem_stall = mem_stallreq
  - ex_stall = mem_stall | ex_stallreq
  - id_stall = ex_stall | id_stallreq
  - if_stall = id_stall | if_stallreq
  - Consequence: when a stage stalls and the stage after it does not, that next pipeline register inserts a bubble.
- FSM:
  - RUN: if an exception is taken and mem_stallreq=0 → COMMIT. If an exception is taken and mem_stallreq=1 → HOLD. Otherwise stay in RUN.
  - HOLD: all five stalls=1; the exception cause is not re-evaluated. When mem_stallreq=0 → COMMIT.
  - COMMIT (1 cycle): all five stalls=1. Cause, EPC and BadVAddr are latched.
  - FLUSH (1 cycle): registered outputs are flush=1 and flush_pc. For an exception, cp0_excwe=1; for ERET, cp0_eret=1. Stalls are 0. Next state is RUN.
- flush_pc is cp0_epc for ERET and EXC_VECTOR otherwise. cp0_epc_wd = mem_inslot ? mem_pc-4 : mem_pc (32-bit wrap). cp0_badv_wd = mem_badvaddr for AdEL/AdES; for fetch AdEL it is mem_pc.
- Exceptions arriving while in COMMIT or FLUSH are ignored. Flush has priority over stall in every consumer.
- rst asserted in any state returns the FSM to RUN within the same edge. No CP0 strobe fires.
- stall_cnt increments modulo 2^32 and freezes while rst=1.

Decomposition:
- Shared defines in defines.v: exception bit indices, ExcCode constants, FSM state encodings, EXC_VECTOR default.
- One sub-module, int_sync (two-flop synchroniser with width NUM_INT).
- Priority encoding and the FSM stay in pipe_ctrl.

Test Plan:
- Stall cascade: ex_stallreq=1 alone → ex, id and if stalls are 1, mem_stall=0, wb_stall=0, no flush. stall_cnt increases by 1 per cycle.
- Ov at MEM with mem_pc=0x80000010, inslot=0 → COMMIT then FLUSH. flush=1 for exactly 1 cycle, flush_pc=0xBFC00380, exccode=0x0C, epc_wd=0x80000010.
- Sys in a delay slot, mem_pc=0x80000024 → epc_wd=0x80000020, exccode=0x08.
- AdES while mem_stallreq=1 for 3 cycles → HOLD for 3 cycles with all stalls=1, then COMMIT, then flush. badv_wd=mem_badvaddr, exccode=0x05.
- ERET with cp0_epc=0x80001000 → flush_pc=0x80001000, cp0_eret=1, cp0_excwe=0.
- ext_int[2] rises, IE=1, EXL=0, IM[12]=1 → int_pending[2]=1 after 2 edges. A MEM Int with RI also set yields exccode=0x00. The same stimulus with EXL=1 yields no flush.
